// File: rtl/tt_pwm_multi.sv
// ---------------------------------------------------------------------------
// tt_pwm_multi
//   Multi-channel edge-aligned PWM generator. All channels share one
//   prescaled counter that runs 0 .. 2^WIDTH-2 and then wraps, so one period
//   is 2^WIDTH-1 ticks long. Each channel compares the counter against its
//   own duty value. A duty of all-ones is treated as "always high".
//
//   Register map (write-only):
//     0x00        EN   [CHANNELS-1:0]  channel enable
//     0x01        MODE [CHANNELS-1:0]  1 = PWM, 0 = static high
//     0x02        PRESC[7:0]           tick every PRESC+1 clk cycles
//     0x10 + i    DUTY[i][WIDTH-1:0]   for i < CHANNELS
//   Writes to any other address are ignored, and so are the wr_data bits
//   above each register's width.
//
//   Build option:
//     PWM_SHADOW_EN  defined     : DUTY writes go to a pending register that
//                                  is copied to the active duty on the wrap
//                                  tick only.
//                    not defined : DUTY writes land in the active duty at
//                                  once.
//
//   Ports:
//     clk           single clock, rising edge
//     rst           asynchronous active-high reset
//     wr_en         register write strobe, one write per cycle
//     wr_addr[4:0]  register address
//     wr_data[15:0] write data, only the low bits are used
//     pwm_out       registered channel outputs
//     period_start  one-cycle pulse, registered, on the counter wrap
//
//   While EN is all zero, the counter and the prescaler hold their values.
//   After a reset, therefore, period_start stays low until a channel is
//   enabled, and the first period starts at cnt = 0.
// ---------------------------------------------------------------------------
module tt_pwm_multi #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [15:0]         wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam int unsigned PRESC_W = 8;
  localparam logic [4:0]  ADDR_EN    = 5'h00;
  localparam logic [4:0]  ADDR_MODE  = 5'h01;
  localparam logic [4:0]  ADDR_PRESC = 5'h02;
  // Last counter value before the wrap: 2^WIDTH-2.
  localparam logic [WIDTH-1:0] CNT_LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] DUTY_FULL = '1;

  // Control registers
  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] mode;
  logic [PRESC_W-1:0]  presc;

  // Timebase state
  logic [PRESC_W-1:0]  presc_cnt;
  logic [WIDTH-1:0]    cnt;

  // Combinational decode and timebase strobes
  logic                sel_en_c;
  logic                sel_mode_c;
  logic                sel_presc_c;
  logic                sel_duty_c;
  logic                run_c;
  logic                tick_c;
  logic                wrap_c;
  logic [CHANNELS-1:0] pwm_next_c;

  // Address decode. A DUTY slot exists only below CHANNELS.
  always_comb begin
    sel_en_c    = 1'b0;
    sel_mode_c  = 1'b0;
    sel_presc_c = 1'b0;
    sel_duty_c  = 1'b0;
    if (wr_en) begin
      sel_en_c    = (wr_addr == ADDR_EN);
      sel_mode_c  = (wr_addr == ADDR_MODE);
      sel_presc_c = (wr_addr == ADDR_PRESC);
      sel_duty_c  = wr_addr[4] && ({1'b0, wr_addr[3:0]} < 5'(CHANNELS));
    end
  end

  // Control register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en    <= '0;
      mode  <= '0;
      presc <= '0;
    end else begin
      if (sel_en_c)    en    <= wr_data[CHANNELS-1:0];
      if (sel_mode_c)  mode  <= wr_data[CHANNELS-1:0];
      if (sel_presc_c) presc <= wr_data[PRESC_W-1:0];
    end
  end

  // Timebase strobes. The timebase runs only while at least one channel is enabled.
  always_comb begin
    run_c  = |en;
    tick_c = run_c && (presc_cnt == presc);
    wrap_c = tick_c && (cnt == CNT_LAST);
  end

  // Prescaler. A PRESC write restarts the divide from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (sel_presc_c) begin
      presc_cnt <= '0;
    end else if (tick_c) begin
      presc_cnt <= '0;
    end else if (run_c) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // Shared period counter: 0 .. 2^WIDTH-2, then wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= wrap_c ? '0 : cnt + WIDTH'(1);
    end
  end

  // Period marker, aligned with the cycle in which cnt reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap_c;
    end
  end

  // Per-channel duty storage and compare
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             duty_we_c;
    logic             raw_c;
    logic [WIDTH-1:0] duty_act;

    assign duty_we_c = sel_duty_c && (wr_addr[3:0] == 4'(i));

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0] duty_pend;

    // Pending duty is loaded by register writes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_pend <= '0;
      end else if (duty_we_c) begin
        duty_pend <= wr_data[WIDTH-1:0];
      end
    end

    // On a write in the wrap cycle, the old pending value is copied,
    // because the register still holds it in that cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_act <= '0;
      end else if (wrap_c) begin
        duty_act <= duty_pend;
      end
    end
`else
    // Direct update; the next compare uses the new duty.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_act <= '0;
      end else if (duty_we_c) begin
        duty_act <= wr_data[WIDTH-1:0];
      end
    end
`endif

    // All-ones forces the output high. cnt never reaches all-ones, so the
    // channel then stays high for the whole period.
    assign raw_c         = (duty_act == DUTY_FULL) ? 1'b1 : (cnt < duty_act);
    assign pwm_next_c[i] = en[i] & (~mode[i] | raw_c);
  end : g_ch

  // Registered outputs. The output register adds one cycle after a cnt change
  // or a control write, with no glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next_c;
    end
  end

endmodule : tt_pwm_multi

// File: tb/tb_tt_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_tt_pwm_multi
//   Self-checking bench for tt_pwm_multi (CHANNELS=8, WIDTH=8). A behavioural
//   model keeps a running tick total (cnt = ticks mod 255) and the register
//   file, and predicts pwm_out and period_start for every clock. Directed
//   scenarios also count high cycles and pulse spacing against fixed figures.
// ---------------------------------------------------------------------------
module tb_tt_pwm_multi;

  localparam int CH   = 8;
  localparam int W    = 8;
  localparam int PER  = (1 << W) - 1;
  localparam int FULL = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [15:0]   wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_start;

  tt_pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [CH-1:0]   m_en;
  bit [CH-1:0]   m_mode;
  int            m_presc;
  int            m_duty_pend [CH];
  int            m_duty_act  [CH];
  int            m_ticks;
  int            m_phase;
  logic [CH-1:0] m_pwm;
  bit            m_ps;

  function automatic void model_reset();
    m_en = '0; m_mode = '0; m_presc = 0; m_ticks = 0; m_phase = 0;
    m_pwm = '0; m_ps = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_duty_pend[i] = 0;
      m_duty_act[i]  = 0;
    end
  endfunction

  // Apply one rising edge: outputs follow the pre-edge state, then the state advances.
  function automatic void model_edge(input bit we, input int addr, input int data);
    int cnt;
    bit run, tick, wrap, raw;
    cnt  = m_ticks % PER;
    run  = (m_en != '0);
    tick = run && ((m_phase % (m_presc + 1)) == m_presc);
    wrap = tick && (cnt == PER - 1);
    for (int i = 0; i < CH; i++) begin
      raw      = (m_duty_act[i] == FULL) ? 1'b1 : (cnt < m_duty_act[i]);
      m_pwm[i] = m_en[i] & (m_mode[i] ? raw : 1'b1);
    end
    m_ps = wrap;
    if (tick) m_ticks++;
    if (run)  m_phase++;
`ifdef PWM_SHADOW_EN
    if (wrap) for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_pend[i];
`endif
    if (we) begin
      if (addr == 0)      m_en = data[CH-1:0];
      else if (addr == 1) m_mode = data[CH-1:0];
      else if (addr == 2) begin
        m_presc = data & 'hFF;
        m_phase = 0;
      end else if (addr >= 16 && addr - 16 < CH) begin
`ifdef PWM_SHADOW_EN
        m_duty_pend[addr-16] = data & FULL;
`else
        m_duty_act[addr-16] = data & FULL;
`endif
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // One clock, with an optional register write, checked against the model.
  task automatic cyc(input bit we = 1'b0, input int addr = 0, input int data = 0);
    wr_en   = we;
    wr_addr = 5'(addr);
    wr_data = 16'(data);
    @(posedge clk);
    model_edge(we, addr, data);
    #1;
    wr_en = 1'b0;
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic wr(input int addr, input int data);
    cyc(1'b1, addr, data);
  endtask

  // Advance until a period_start pulse; an expired budget is a failure.
  task automatic wait_ps(input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!period_start && n < budget);
    check("ps_timeout", 32'(period_start), 32'd1);
  endtask

  // Run len cycles, counting high cycles of pwm_out[ch] and period_start pulses.
  task automatic measure(input int ch, input int len, output int hi, output int ps);
    hi = 0;
    ps = 0;
    for (int k = 0; k < len; k++) begin
      cyc();
      hi += int'(pwm_out[ch]);
      ps += int'(period_start);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_pwm", 32'(pwm_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int hi, ps;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", 32'(pwm_out), 32'd0);
    check("reset_ps", 32'(period_start), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) cyc();   // idle: counter frozen, no pulses

    // 128/255 duty at PRESC=0
    wr(2, 0); wr('h10, 128); wr(1, 1); wr(0, 1);
    wait_ps(600);
    measure(0, PER, hi, ps);
    check("duty128_hi", 32'(hi), 32'd128);
    check("duty128_ps_cnt", 32'(ps), 32'd1);
    check("duty128_ps_at_255", 32'(period_start), 32'd1);

    // duty 0 then all-ones
    wr('h10, 0);
    wait_ps(600); wait_ps(600);
    measure(0, PER, hi, ps);
    check("duty0_hi", 32'(hi), 32'd0);
    wr('h10, 255);
    wait_ps(600); wait_ps(600);
    measure(0, PER, hi, ps);
    check("duty255_hi", 32'(hi), 32'(PER));

    // PRESC=3, channel 1 at duty 64 -> 256 high clocks of 1020
    wr('h11, 64); wr(1, 3); wr(0, 3); wr(2, 3);
    wait_ps(2500); wait_ps(2500);
    measure(1, 4 * PER, hi, ps);
    check("presc3_hi", 32'(hi), 32'd256);
    check("presc3_ps_cnt", 32'(ps), 32'd1);

    // static-high mode: EN write visible two cycles later
    do_reset();
    wr(0, 'hFF);
    cyc();
    check("static_en_ff", 32'(pwm_out), 32'hFF);
    wr(0, 0);
    cyc();
    check("static_en_00", 32'(pwm_out), 32'h00);

    // duty 50 -> 200 in mid-period
    do_reset();
    wr('h10, 50); wr(1, 1); wr(0, 1);
    wait_ps(600); wait_ps(600);
    measure(0, PER, hi, ps);
    check("duty50_hi", 32'(hi), 32'd50);
    repeat (99) cyc();
    wr('h10, 200);
    wait_ps(600);
    measure(0, PER, hi, ps);
    check("duty200_hi", 32'(hi), 32'd200);

    // reset near cnt=100 while output high, then write to an unmapped address
    wait_ps(600);
    repeat (100) cyc();
    check("pre_rst_high", 32'(pwm_out[0]), 32'd1);
    do_reset();
    wr('h1F, 'hFFFF); wr(1, 1); wr(0, 1);
    measure(0, 2 * PER, hi, ps);
    check("post_rst_duty0_hi", 32'(hi), 32'd0);

    // randomized register traffic
    do_reset();
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 24) == 0) begin
        int a, d;
        a = $urandom_range(0, 31);
        d = int'($urandom_range(0, 65535));
        if (a == 2) d = (d & 'hFF00) | int'($urandom_range(0, 3));
        wr(a, d);
      end else begin
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_tt_pwm_multi
